// File: rtl/filter_window_ctrl.sv
// filter_window_ctrl: sequencing controller for the 3x3 mean filter.
// Keeps the two previous image rows in line buffers, presents a vertical
// three-pixel tap column per accepted pixel, tracks frame position and
// flags full-window results, frame completion and mid-frame restarts.
module filter_window_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int DW    = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sof,
  input  logic                       pix_valid,
  input  logic [DW-1:0]              pix_in,
  output logic                       en,
  output logic [DW-1:0]              r0,
  output logic [DW-1:0]              r1,
  output logic [DW-1:0]              r2,
  output logic                       win_valid,
  output logic [$clog2(IMG_H)-1:0]   out_row,
  output logic [$clog2(IMG_W)-1:0]   out_col,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       sof_err
);

  localparam int RW = $clog2(IMG_H);
  localparam int CW = $clog2(IMG_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;

  // Line buffers: lbA holds row n-2, lbB holds row n-1 (data only, not reset)
  logic [DW-1:0] r_lb_a [IMG_W];
  logic [DW-1:0] r_lb_b [IMG_W];

  logic [DW-1:0] r_tap0_p1;
  logic [DW-1:0] r_tap1_p1;
  logic [DW-1:0] r_tap2_p1;
  logic          r_en_p1;
  logic          r_win_p1;
  logic [RW-1:0] r_row_p1;
  logic [CW-1:0] r_col_p1;
  logic          r_frame_done;
  logic          r_sof_err;

  logic          w_in_frame;
  logic          w_restart;
  logic          w_accept;
  logic          w_run_pix;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col;
  logic          w_col_last;
  logic          w_row_last;

  // sof qualified by pix_valid restarts the frame from any state; position
  // of the accepted pixel is forced to (0,0) in that case.
  assign w_in_frame = (r_state == S_FILL) || (r_state == S_RUN);
  assign w_restart  = pix_valid && sof;
  assign w_accept   = w_restart || (pix_valid && w_in_frame);
  assign w_row      = w_restart ? '0 : r_row;
  assign w_col      = w_restart ? '0 : r_col;
  assign w_col_last = (w_col == CW'(IMG_W - 1));
  assign w_row_last = (w_row == RW'(IMG_H - 1));
  assign w_run_pix  = w_accept && !w_restart && (r_state == S_RUN);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic: FILL covers rows 0-1, RUN rows 2..IMG_H-1, DONE one cycle
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_restart) w_state_nxt = S_FILL;
      end
      S_FILL: begin
        if (w_restart)
          w_state_nxt = S_FILL;
        else if (pix_valid && (w_row == RW'(1)) && w_col_last)
          w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_restart)
          w_state_nxt = S_FILL;
        else if (pix_valid && w_row_last && w_col_last)
          w_state_nxt = S_DONE;
      end
      S_DONE: begin
        w_state_nxt = w_restart ? S_FILL : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Raster position of the next expected pixel; exact wrap compares
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : w_row + RW'(1);
      end else begin
        r_col <= w_col + CW'(1);
        r_row <= w_row;
      end
    end
  end

  // Line buffer shift, read-before-write on the same column
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_lb_a[w_col] <= r_lb_b[w_col];
      r_lb_b[w_col] <= pix_in;
    end
  end

  // ---- stage p1: tap column, strobes and position, one cycle after acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tap0_p1    <= '0;
      r_tap1_p1    <= '0;
      r_tap2_p1    <= '0;
      r_row_p1     <= '0;
      r_col_p1     <= '0;
      r_en_p1      <= 1'b0;
      r_win_p1     <= 1'b0;
      r_frame_done <= 1'b0;
      r_sof_err    <= 1'b0;
    end else begin
      r_en_p1      <= w_run_pix;
      r_win_p1     <= w_run_pix && (w_col >= CW'(2));
      r_frame_done <= (r_state == S_DONE);
      r_sof_err    <= w_restart && w_in_frame;
      if (w_accept) begin
        r_tap0_p1 <= r_lb_a[w_col];
        r_tap1_p1 <= r_lb_b[w_col];
        r_tap2_p1 <= pix_in;
        r_row_p1  <= w_row;
        r_col_p1  <= w_col;
      end
    end
  end

  assign r0         = r_tap0_p1;
  assign r1         = r_tap1_p1;
  assign r2         = r_tap2_p1;
  assign en         = r_en_p1;
  assign win_valid  = r_win_p1;
  assign out_row    = r_row_p1;
  assign out_col    = r_col_p1;
  assign frame_done = r_frame_done;
  assign sof_err    = r_sof_err;
  assign busy       = w_in_frame;

endmodule

// File: tb/tb_filter_window_ctrl.sv
// Directed bench for filter_window_ctrl at IMG_W=IMG_H=4, pixel = row*16+col.
module tb_filter_window_ctrl;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst;
  logic       sof;
  logic       pix_valid;
  logic [7:0] pix_in;
  logic       en;
  logic [7:0] r0, r1, r2;
  logic       win_valid;
  logic [1:0] out_row;
  logic [1:0] out_col;
  logic       busy;
  logic       frame_done;
  logic       sof_err;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic       sof;
    logic [7:0] pix;
    logic       en;
    logic       win;
    logic [7:0] r0;
    logic [7:0] r1;
    logic [7:0] r2;
    logic [1:0] row;
    logic [1:0] col;
    logic       busy;
  } vec_t;

  vec_t vt [N];

  filter_window_ctrl #(.IMG_W(W), .IMG_H(H), .DW(8)) dut (
    .clk(clk), .rst(rst), .sof(sof), .pix_valid(pix_valid), .pix_in(pix_in),
    .en(en), .r0(r0), .r1(r1), .r2(r2), .win_valid(win_valid),
    .out_row(out_row), .out_col(out_col), .busy(busy),
    .frame_done(frame_done), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic s, input logic v, input logic [7:0] p);
    @(negedge clk);
    sof = s; pix_valid = v; pix_in = p;
    @(posedge clk);
    #1;
  endtask

  // One contiguous (or gapped) frame from the table
  task automatic run_frame(input bit gaps, input bit serr_first, input bit fd_first);
    int n_en = 0;
    int n_win = 0;
    for (int i = 0; i < N; i++) begin
      step(vt[i].sof, 1'b1, vt[i].pix);
      check($sformatf("en[%0d]", i), en, vt[i].en);
      check($sformatf("win[%0d]", i), win_valid, vt[i].win);
      check($sformatf("row[%0d]", i), out_row, vt[i].row);
      check($sformatf("col[%0d]", i), out_col, vt[i].col);
      check($sformatf("busy[%0d]", i), busy, vt[i].busy);
      check($sformatf("sof_err[%0d]", i), sof_err, (i == 0) && serr_first);
      check($sformatf("frame_done[%0d]", i), frame_done, (i == 0) && fd_first);
      check($sformatf("r2[%0d]", i), r2, vt[i].r2);
      if (vt[i].en) begin
        check($sformatf("r0[%0d]", i), r0, vt[i].r0);
        check($sformatf("r1[%0d]", i), r1, vt[i].r1);
      end
      n_en  += int'(en);
      n_win += int'(win_valid);
      if (gaps && i < N - 1) begin
        step(1'b0, 1'b0, 8'hEE);
        check($sformatf("gap_en[%0d]", i), en, 1'b0);
        check($sformatf("gap_win[%0d]", i), win_valid, 1'b0);
        check($sformatf("gap_r2[%0d]", i), r2, vt[i].r2);
        check($sformatf("gap_col[%0d]", i), out_col, vt[i].col);
      end
    end
    check("en_count", n_en, 8);
    check("win_count", n_win, 4);
  endtask

  // Idle cycles after the last pixel: frame_done exactly one cycle
  task automatic finish_frame();
    step(1'b0, 1'b0, 8'h00);
    check("frame_done_pulse", frame_done, 1'b1);
    check("busy_after_done", busy, 1'b0);
    check("en_after_done", en, 1'b0);
    step(1'b0, 1'b0, 8'h00);
    check("frame_done_low", frame_done, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      int rr, cc;
      rr = i / W;
      cc = i % W;
      vt[i].sof  = (i == 0);
      vt[i].pix  = 8'(rr * 16 + cc);
      vt[i].en   = (rr >= 2);
      vt[i].win  = (rr >= 2) && (cc >= 2);
      vt[i].r0   = 8'((rr - 2) * 16 + cc);
      vt[i].r1   = 8'((rr - 1) * 16 + cc);
      vt[i].r2   = 8'(rr * 16 + cc);
      vt[i].row  = 2'(rr);
      vt[i].col  = 2'(cc);
      vt[i].busy = (i < N - 1);
    end

    rst = 1'b1; sof = 1'b0; pix_valid = 1'b0; pix_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_en", en, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_taps", {r0, r1, r2}, 24'h0);
    check("reset_pos", {out_row, out_col}, 4'h0);
    check("reset_flags", {win_valid, frame_done, sof_err}, 3'b000);

    // Contiguous frame
    run_frame(1'b0, 1'b0, 1'b0);
    finish_frame();

    // Same frame with a gap after every pixel
    run_frame(1'b1, 1'b0, 1'b0);
    finish_frame();

    // Pixels without sof while idle are dropped
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h55);
      check("idle_en", en, 1'b0);
      check("idle_busy", busy, 1'b0);
      check("idle_col_hold", out_col, 2'd3);
    end
    step(1'b1, 1'b1, 8'h00);
    check("sof_busy", busy, 1'b1);
    check("sof_pos", {out_row, out_col}, 4'h0);
    check("sof_no_err", sof_err, 1'b0);

    // Run into row 2, then restart at (2,1)
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, vt[i].pix);
      check("pre_abort_fd", frame_done, 1'b0);
      check("pre_abort_en", en, vt[i].en);
    end
    check("pre_abort_r1", r1, 8'h10);
    run_frame(1'b0, 1'b1, 1'b0);
    finish_frame();

    // Asynchronous reset mid-RUN
    for (int i = 0; i <= 9; i++) step(vt[i].sof, 1'b1, vt[i].pix);
    check("pre_rst_en", en, 1'b1);
    pix_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_en", en, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_taps", {r0, r1, r2}, 24'h0);
    check("arst_pos", {out_row, out_col}, 4'h0);
    check("arst_flags", {win_valid, frame_done, sof_err}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
    run_frame(1'b0, 1'b0, 1'b0);
    finish_frame();

    // Back-to-back frames, second sof lands in the DONE cycle
    run_frame(1'b0, 1'b0, 1'b0);
    run_frame(1'b0, 1'b0, 1'b1);
    finish_frame();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
